// File: rtl/pingpong_bank_sched_pkg.sv
// Shared types and widths for the ping-pong bank scheduler.
package pingpong_pkg;

    localparam int DW_DEFAULT = 512;
    localparam int CPP_W      = 8;
    localparam int PPG_W      = 16;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_STREAM = 2'd2
    } state_t;

endpackage

// File: rtl/pingpong_bank_sched_pkt_group_counter.sv
// Beat and packet counters for one group; limits are latched at group start so
// configuration changes only take effect on the following group.
module pkt_group_counter
    import pingpong_pkg::*;
(
    input  logic             clk,
    input  logic             resetn,
    input  logic             load,
    input  logic [CPP_W-1:0] cfg_cpp,
    input  logic [PPG_W-1:0] cfg_ppg,
    input  logic             beat_hs,
    output logic             last_beat,
    output logic             last_packet
);

    logic [CPP_W-1:0] cpp_q;
    logic [CPP_W-1:0] beat;
    logic [PPG_W-1:0] ppg_q;
    logic [PPG_W-1:0] packet;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            cpp_q  <= CPP_W'(1);
            ppg_q  <= PPG_W'(1);
            beat   <= CPP_W'(1);
            packet <= PPG_W'(1);
        end else if (load) begin
            // A zero limit would never match a counter that starts at 1.
            cpp_q  <= (cfg_cpp == '0) ? CPP_W'(1) : cfg_cpp;
            ppg_q  <= (cfg_ppg == '0) ? PPG_W'(1) : cfg_ppg;
            beat   <= CPP_W'(1);
            packet <= PPG_W'(1);
        end else if (beat_hs) begin
            if (last_beat) begin
                beat   <= CPP_W'(1);
                packet <= last_packet ? PPG_W'(1) : packet + PPG_W'(1);
            end else begin
                beat <= beat + CPP_W'(1);
            end
        end
    end

    assign last_beat   = (beat == cpp_q);
    assign last_packet = (packet == ppg_q);

endmodule

// File: rtl/pingpong_bank_sched.sv
// Steers packet groups alternately to two downstream banks, stalling the input
// until the target bank has been released by its consumer.
module pingpong_bank_sched
    import pingpong_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             enable,
    input  logic [CPP_W-1:0] cfg_cycles_per_packet,
    input  logic [PPG_W-1:0] cfg_packets_per_group,
    input  logic [1:0]       bank_release,
    input  logic [DW-1:0]    AXIS_IN_TDATA,
    input  logic             AXIS_IN_TVALID,
    output logic             AXIS_IN_TREADY,
    output logic [DW-1:0]    AXIS_OUT0_TDATA,
    output logic             AXIS_OUT0_TLAST,
    output logic             AXIS_OUT0_TVALID,
    input  logic             AXIS_OUT0_TREADY,
    output logic [DW-1:0]    AXIS_OUT1_TDATA,
    output logic             AXIS_OUT1_TLAST,
    output logic             AXIS_OUT1_TVALID,
    input  logic             AXIS_OUT1_TREADY,
    output logic             group_done,
    output logic             group_bank,
    output logic [1:0]       bank_busy,
    output logic             active_bank,
    output logic [31:0]      groups_completed,
    output logic [31:0]      stall_cycles
);

    state_t     state;
    logic       streaming;
    logic       sel0;
    logic       sel1;
    logic       in_hs;
    logic       last_beat;
    logic       last_packet;
    logic       group_end;
    logic       target_free;
    logic       load;
    logic [1:0] busy_next;

    assign streaming = (state == S_STREAM);
    assign sel0      = streaming && !active_bank;
    assign sel1      = streaming && active_bank;

    assign AXIS_IN_TREADY   = (sel0 && AXIS_OUT0_TREADY) || (sel1 && AXIS_OUT1_TREADY);
    assign AXIS_OUT0_TVALID = sel0 && AXIS_IN_TVALID;
    assign AXIS_OUT1_TVALID = sel1 && AXIS_IN_TVALID;
    assign AXIS_OUT0_TDATA  = sel0 ? AXIS_IN_TDATA : '0;
    assign AXIS_OUT1_TDATA  = sel1 ? AXIS_IN_TDATA : '0;
    assign AXIS_OUT0_TLAST  = AXIS_OUT0_TVALID && last_beat;
    assign AXIS_OUT1_TLAST  = AXIS_OUT1_TVALID && last_beat;

    assign in_hs       = AXIS_IN_TVALID && AXIS_IN_TREADY;
    assign group_end   = in_hs && last_beat && last_packet;
    assign target_free = !bank_busy[active_bank] || bank_release[active_bank];
    assign load        = (state == S_WAIT) && target_free;

    // Release is applied first so a same-cycle set on that bank wins.
    always_comb begin
        busy_next = bank_busy & ~bank_release;
        if (group_end) begin
            busy_next[active_bank] = 1'b1;
        end
    end

    pkt_group_counter u_counter (
        .clk         (clk),
        .resetn      (resetn),
        .load        (load),
        .cfg_cpp     (cfg_cycles_per_packet),
        .cfg_ppg     (cfg_packets_per_group),
        .beat_hs     (in_hs),
        .last_beat   (last_beat),
        .last_packet (last_packet)
    );

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state            <= S_IDLE;
            active_bank      <= 1'b0;
            bank_busy        <= 2'b00;
            group_done       <= 1'b0;
            group_bank       <= 1'b0;
            groups_completed <= '0;
            stall_cycles     <= '0;
        end else begin
            group_done <= 1'b0;
            bank_busy  <= busy_next;
            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (target_free) begin
                        state <= S_STREAM;
                    end else if (AXIS_IN_TVALID && (stall_cycles != '1)) begin
                        stall_cycles <= stall_cycles + 32'd1;
                    end
                end
                S_STREAM: begin
                    if (group_end) begin
                        group_done       <= 1'b1;
                        group_bank       <= active_bank;
                        groups_completed <= groups_completed + 32'd1;
                        active_bank      <= ~active_bank;
                        state            <= enable ? S_WAIT : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pingpong_bank_sched.sv
// Scoreboard bench: tests queue expected beats and group completions, a
// negedge monitor pops and compares whenever an output handshakes.
module tb_pingpong_bank_sched;
    import pingpong_pkg::*;

    localparam int DW = 512;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          enable = 1'b0;
    logic [7:0]    cfg_cycles_per_packet = 8'd1;
    logic [15:0]   cfg_packets_per_group = 16'd1;
    logic [1:0]    rel_auto = 2'b00;
    logic [1:0]    rel_man = 2'b00;
    logic [1:0]    bank_release;
    logic [DW-1:0] AXIS_IN_TDATA = '0;
    logic          AXIS_IN_TVALID = 1'b0;
    logic          AXIS_IN_TREADY;
    logic [DW-1:0] AXIS_OUT0_TDATA;
    logic          AXIS_OUT0_TLAST;
    logic          AXIS_OUT0_TVALID;
    logic          AXIS_OUT0_TREADY = 1'b1;
    logic [DW-1:0] AXIS_OUT1_TDATA;
    logic          AXIS_OUT1_TLAST;
    logic          AXIS_OUT1_TVALID;
    logic          AXIS_OUT1_TREADY = 1'b1;
    logic          group_done;
    logic          group_bank;
    logic [1:0]    bank_busy;
    logic          active_bank;
    logic [31:0]   groups_completed;
    logic [31:0]   stall_cycles;

    assign bank_release = rel_auto | rel_man;

    pingpong_bank_sched #(.DW(DW)) dut (
        .clk                   (clk),
        .resetn                (resetn),
        .enable                (enable),
        .cfg_cycles_per_packet (cfg_cycles_per_packet),
        .cfg_packets_per_group (cfg_packets_per_group),
        .bank_release          (bank_release),
        .AXIS_IN_TDATA         (AXIS_IN_TDATA),
        .AXIS_IN_TVALID        (AXIS_IN_TVALID),
        .AXIS_IN_TREADY        (AXIS_IN_TREADY),
        .AXIS_OUT0_TDATA       (AXIS_OUT0_TDATA),
        .AXIS_OUT0_TLAST       (AXIS_OUT0_TLAST),
        .AXIS_OUT0_TVALID      (AXIS_OUT0_TVALID),
        .AXIS_OUT0_TREADY      (AXIS_OUT0_TREADY),
        .AXIS_OUT1_TDATA       (AXIS_OUT1_TDATA),
        .AXIS_OUT1_TLAST       (AXIS_OUT1_TLAST),
        .AXIS_OUT1_TVALID      (AXIS_OUT1_TVALID),
        .AXIS_OUT1_TREADY      (AXIS_OUT1_TREADY),
        .group_done            (group_done),
        .group_bank            (group_bank),
        .bank_busy             (bank_busy),
        .active_bank           (active_bank),
        .groups_completed      (groups_completed),
        .stall_cycles          (stall_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        bank;
        logic [31:0] tag;
        logic        last;
    } beat_t;

    beat_t       exp_q[$];
    logic        gd_q[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] tag = 32'd1;
    logic [31:0] exp_tag = 32'd1;
    bit          auto_rel = 1'b0;
    bit          tog_en = 1'b0;
    logic [1:0]  dl0 = 2'b00;
    logic [1:0]  dl1 = 2'b00;

    function automatic logic [DW-1:0] pat(input logic [31:0] t);
        return {16{t}};
    endfunction

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, got, exp);
        end
    endtask

    task automatic expect_beats(input logic b, input int n, input int cpp);
        beat_t e;
        for (int i = 0; i < n; i++) begin
            e.bank = b;
            e.tag  = exp_tag;
            e.last = (((i + 1) % cpp) == 0);
            exp_q.push_back(e);
            exp_tag++;
        end
    endtask

    // Called just after a posedge; holds TVALID until the beat handshakes.
    task automatic send_one(input logic [1:0] rel);
        AXIS_IN_TDATA  = pat(tag);
        AXIS_IN_TVALID = 1'b1;
        for (int w = 0; w < 200; w++) begin
            @(negedge clk);
            if (AXIS_IN_TREADY) begin
                rel_man = rel;
                @(posedge clk);
                #1;
                rel_man        = 2'b00;
                AXIS_IN_TVALID = 1'b0;
                tag++;
                return;
            end
        end
        checks++;
        errors++;
        $display("FAIL send_timeout: tag %0d not accepted within 200 cycles", tag);
        AXIS_IN_TVALID = 1'b0;
    endtask

    task automatic send(input int n, input bit gaps);
        for (int i = 0; i < n; i++) begin
            if (gaps && (i % 2 == 1)) begin
                @(posedge clk);
                #1;
            end
            send_one(2'b00);
        end
    endtask

    task automatic do_reset();
        resetn         = 1'b0;
        enable         = 1'b0;
        AXIS_IN_TVALID = 1'b0;
        auto_rel       = 1'b0;
        tog_en         = 1'b0;
        rel_man        = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    task automatic settle_and_drain(input string nm);
        repeat (6) @(posedge clk);
        @(negedge clk);
        chk({nm, "_beats_left"}, exp_q.size(), 0);
        chk({nm, "_done_left"}, gd_q.size(), 0);
        exp_q.delete();
        gd_q.delete();
    endtask

    task automatic mon_beat(input logic b, input logic [DW-1:0] d, input logic l, input logic other_v);
        beat_t e;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got beat on bank %0d, expected none", b);
        end else begin
            e = exp_q.pop_front();
            chk("beat_bank", b, e.bank);
            chk("beat_data", d, pat(e.tag));
            chk("beat_last", l, e.last);
            chk("other_valid", other_v, 1'b0);
        end
    endtask

    always @(negedge clk) begin
        if (resetn) begin
            if (AXIS_OUT0_TVALID && AXIS_OUT0_TREADY)
                mon_beat(1'b0, AXIS_OUT0_TDATA, AXIS_OUT0_TLAST, AXIS_OUT1_TVALID);
            if (AXIS_OUT1_TVALID && AXIS_OUT1_TREADY)
                mon_beat(1'b1, AXIS_OUT1_TDATA, AXIS_OUT1_TLAST, AXIS_OUT0_TVALID);
            if (group_done) begin
                if (gd_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_group_done: bank %0d, expected none", group_bank);
                end else begin
                    chk("group_bank", group_bank, gd_q.pop_front());
                end
            end
        end
    end

    // Consumer model: release a bank two cycles after its group_done.
    initial forever begin
        @(posedge clk);
        #1;
        rel_auto = auto_rel ? dl1 : 2'b00;
        dl1      = dl0;
        dl0      = group_done ? (group_bank ? 2'b10 : 2'b01) : 2'b00;
        AXIS_OUT0_TREADY = tog_en ? ~AXIS_OUT0_TREADY : 1'b1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        do_reset();
        @(negedge clk);
        chk("rst_active", active_bank, 1'b0);
        chk("rst_busy", bank_busy, 2'b00);
        chk("rst_done", group_done, 1'b0);
        chk("rst_gbank", group_bank, 1'b0);
        chk("rst_groups", groups_completed, 0);
        chk("rst_stall", stall_cycles, 0);
        chk("rst_tready", AXIS_IN_TREADY, 1'b0);
        chk("rst_v0", AXIS_OUT0_TVALID, 1'b0);
        chk("rst_v1", AXIS_OUT1_TVALID, 1'b0);
        chk("rst_l0", AXIS_OUT0_TLAST, 1'b0);
        chk("rst_l1", AXIS_OUT1_TLAST, 1'b0);

        // Single-beat groups alternating banks
        @(posedge clk);
        #1;
        cfg_cycles_per_packet = 8'd1;
        cfg_packets_per_group = 16'd1;
        auto_rel = 1'b1;
        for (int g = 0; g < 4; g++) begin
            expect_beats(g[0], 1, 1);
            gd_q.push_back(g[0]);
        end
        enable = 1'b1;
        send(4, 1'b0);
        settle_and_drain("t1");
        chk("t1_groups", groups_completed, 4);

        // Bank stall with no releases
        do_reset();
        cfg_cycles_per_packet = 8'd4;
        cfg_packets_per_group = 16'd2;
        expect_beats(1'b0, 8, 4);
        expect_beats(1'b1, 8, 4);
        gd_q.push_back(1'b0);
        gd_q.push_back(1'b1);
        enable = 1'b1;
        send(16, 1'b0);
        AXIS_IN_TDATA  = pat(tag);
        AXIS_IN_TVALID = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            chk("t2_tready", AXIS_IN_TREADY, 1'b0);
            chk("t2_busy", bank_busy, 2'b11);
            chk("t2_stall", stall_cycles, i - 1);
        end
        @(posedge clk);
        #1;
        AXIS_IN_TVALID = 1'b0;
        rel_man = 2'b01;
        @(posedge clk);
        #1;
        rel_man = 2'b00;
        @(negedge clk);
        chk("t2_tready_after_rel", AXIS_IN_TREADY, 1'b1);
        chk("t2_active_after_rel", active_bank, 1'b0);
        chk("t2_busy_after_rel", bank_busy, 2'b10);
        chk("t2_stall_after_rel", stall_cycles, 10);
        expect_beats(1'b0, 8, 4);
        gd_q.push_back(1'b0);
        @(posedge clk);
        #1;
        send(8, 1'b0);
        settle_and_drain("t2");
        chk("t2_groups", groups_completed, 3);
        chk("t2_busy_end", bank_busy, 2'b11);
        chk("t2_stall_end", stall_cycles, 10);

        // Back-pressure and input gaps
        do_reset();
        cfg_cycles_per_packet = 8'd3;
        cfg_packets_per_group = 16'd2;
        tog_en = 1'b1;
        expect_beats(1'b0, 6, 3);
        gd_q.push_back(1'b0);
        enable = 1'b1;
        send(6, 1'b1);
        settle_and_drain("t3");
        chk("t3_groups", groups_completed, 1);
        chk("t3_busy", bank_busy, 2'b01);
        tog_en = 1'b0;

        // Zero config, then a mid-group cfg change
        do_reset();
        auto_rel = 1'b1;
        cfg_cycles_per_packet = 8'd0;
        cfg_packets_per_group = 16'd0;
        expect_beats(1'b0, 1, 1);
        expect_beats(1'b1, 1, 1);
        gd_q.push_back(1'b0);
        gd_q.push_back(1'b1);
        enable = 1'b1;
        send(2, 1'b0);
        cfg_cycles_per_packet = 8'd2;
        cfg_packets_per_group = 16'd1;
        expect_beats(1'b0, 2, 2);
        gd_q.push_back(1'b0);
        send_one(2'b00);
        cfg_cycles_per_packet = 8'd5;
        send_one(2'b00);
        expect_beats(1'b1, 5, 5);
        gd_q.push_back(1'b1);
        send(5, 1'b0);
        settle_and_drain("t4");
        chk("t4_groups", groups_completed, 4);

        // Enable and release corners
        do_reset();
        cfg_cycles_per_packet = 8'd2;
        cfg_packets_per_group = 16'd1;
        expect_beats(1'b0, 2, 2);
        gd_q.push_back(1'b0);
        enable = 1'b1;
        send_one(2'b00);
        enable = 1'b0;
        send_one(2'b00);
        AXIS_IN_TDATA  = pat(tag);
        AXIS_IN_TVALID = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t5_idle_tready", AXIS_IN_TREADY, 1'b0);
        end
        chk("t5_idle_active", active_bank, 1'b1);
        chk("t5_idle_busy", bank_busy, 2'b01);
        chk("t5_idle_stall", stall_cycles, 0);
        chk("t5_idle_groups", groups_completed, 1);
        @(posedge clk);
        #1;
        AXIS_IN_TVALID = 1'b0;
        rel_man = 2'b10;
        @(posedge clk);
        #1;
        rel_man = 2'b00;
        @(negedge clk);
        chk("t5_free_release", bank_busy, 2'b01);
        @(posedge clk);
        #1;
        rel_man = 2'b01;
        @(posedge clk);
        #1;
        rel_man = 2'b00;
        @(negedge clk);
        chk("t5_release0", bank_busy, 2'b00);
        @(posedge clk);
        #1;
        enable = 1'b1;
        expect_beats(1'b1, 2, 2);
        gd_q.push_back(1'b1);
        send(2, 1'b0);
        expect_beats(1'b0, 2, 2);
        gd_q.push_back(1'b0);
        send_one(2'b00);
        send_one(2'b11);
        @(negedge clk);
        chk("t5_set_vs_release", bank_busy, 2'b01);
        chk("t5_active", active_bank, 1'b1);
        settle_and_drain("t5");

        // Reset in the middle of a packet
        do_reset();
        cfg_cycles_per_packet = 8'd4;
        cfg_packets_per_group = 16'd1;
        expect_beats(1'b0, 2, 4);
        enable = 1'b1;
        send(2, 1'b0);
        resetn = 1'b0;
        @(posedge clk);
        #1;
        AXIS_IN_TVALID = 1'b1;
        @(negedge clk);
        chk("t6_tready", AXIS_IN_TREADY, 1'b0);
        chk("t6_v0", AXIS_OUT0_TVALID, 1'b0);
        chk("t6_l0", AXIS_OUT0_TLAST, 1'b0);
        chk("t6_v1", AXIS_OUT1_TVALID, 1'b0);
        chk("t6_done", group_done, 1'b0);
        chk("t6_busy", bank_busy, 2'b00);
        chk("t6_active", active_bank, 1'b0);
        chk("t6_groups", groups_completed, 0);
        chk("t6_beats_left", exp_q.size(), 0);
        @(posedge clk);
        #1;
        AXIS_IN_TVALID = 1'b0;
        resetn = 1'b1;
        cfg_cycles_per_packet = 8'd1;
        expect_beats(1'b0, 1, 1);
        gd_q.push_back(1'b0);
        send(1, 1'b0);
        settle_and_drain("t6");
        chk("t6_groups_restart", groups_completed, 1);
        chk("t6_busy_restart", bank_busy, 2'b01);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
